pipelined_alu: RTL and testbench

Parametrised, two-stage pipelined integer ALU for the five-stage datapath's execute stage. It is the successor to the fixed 64-bit combinational ALU. It adds a configurable datapath width, valid/ready handshaking with backpressure, registered carry/overflow/zero flags, a signed set-less-than operation, and an optional barrel shift by operand B. It sits between the ID/EX pipeline register and the EX/MEM writeback path. It accepts one operation per cycle and returns results in issue order.

---
 rtl/pipelined_alu.sv | 139 +++++++++++++
 tb/tb_pipelined_alu.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pipelined_alu.sv
// pipelined_alu: two-stage integer ALU with valid/ready flow control.
// S1 captures operands/opcode; S2 registers result and flags. Outputs are
// driven straight from S2 registers.
// Optional feature macro: ALU_SHIFT_BY_B_EN (SHL/SHR shift by b[SHW-1:0]);
// undefined -> SHL/SHR shift by one and b is ignored.
module pipelined_alu #(
  parameter  int WIDTH = 64,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b1000,
    OP_SHL = 4'b0001,
    OP_SHR = 4'b0101,
    OP_XOR = 4'b0100,
    OP_OR  = 4'b0110,
    OP_AND = 4'b0111,
    OP_SLT = 4'b0010
  } op_e;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       op;
  } req_t;

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             overflow;
    logic             zero;
  } rsp_t;

  // vld_q[1] = S1 holds a beat, vld_q[2] = S2 holds a beat (out_valid)
  logic [2:1] vld_q, vld_d;
  req_t       s1_q, s1_d;
  rsp_t       s2_q, s2_d, alu_rsp;
  logic       s2_ready, s1_load, s2_load;

  // Handshake: S2 frees when empty or popping; S1 frees when empty or moving on
  always_comb begin
    s2_ready = !vld_q[2] | out_ready;
    in_ready = !vld_q[1] | s2_ready;
    s1_load  = in_valid & in_ready;
    s2_load  = vld_q[1] & s2_ready;
  end

  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic [SHW-1:0]   shamt;

  // Execute from S1 registers; unknown opcodes yield zero result and flags
  always_comb begin
    is_sub = (s1_q.op == OP_SUB);
    b_eff  = is_sub ? ~s1_q.b : s1_q.b;
    sum    = {1'b0, s1_q.a} + {1'b0, b_eff} + (WIDTH+1)'(is_sub);
`ifdef ALU_SHIFT_BY_B_EN
    shamt  = s1_q.b[SHW-1:0];
`else
    shamt  = SHW'(1);
`endif
    alu_rsp = '0;
    case (s1_q.op)
      OP_ADD, OP_SUB: begin
        alu_rsp.result   = sum[WIDTH-1:0];
        alu_rsp.carry    = sum[WIDTH];
        // carry into MSB is a^b^sum at that bit; overflow when it differs from carry out
        alu_rsp.overflow = (s1_q.a[WIDTH-1] ^ b_eff[WIDTH-1] ^ sum[WIDTH-1]) ^ sum[WIDTH];
      end
      OP_SHL: alu_rsp.result = s1_q.a << shamt;
      OP_SHR: alu_rsp.result = s1_q.a >> shamt;
      OP_XOR: alu_rsp.result = s1_q.a ^ s1_q.b;
      OP_OR:  alu_rsp.result = s1_q.a | s1_q.b;
      OP_AND: alu_rsp.result = s1_q.a & s1_q.b;
      OP_SLT: alu_rsp.result = {{(WIDTH-1){1'b0}}, ($signed(s1_q.a) < $signed(s1_q.b))};
      default: alu_rsp.result = '0;
    endcase
    case (s1_q.op)
      OP_ADD, OP_SUB, OP_SHL, OP_SHR, OP_XOR, OP_OR, OP_AND, OP_SLT:
        alu_rsp.zero = (alu_rsp.result == '0);
      default: alu_rsp.zero = 1'b0;
    endcase
  end

  // Next-state for both stages; data only moves when the valid handshake allows
  always_comb begin
    s1_d  = s1_q;
    s2_d  = s2_q;
    vld_d = vld_q;
    if (s1_load) begin
      s1_d     = '{a: a, b: b, op: opcode};
      vld_d[1] = 1'b1;
    end else if (s2_load) begin
      vld_d[1] = 1'b0;
    end
    if (s2_load) begin
      s2_d     = alu_rsp;
      vld_d[2] = 1'b1;
    end else if (vld_q[2] & out_ready) begin
      vld_d[2] = 1'b0;
    end
  end

  // Pipeline registers; reset discards any in-flight beats
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      s1_q  <= '0;
      s2_q  <= '0;
    end else begin
      vld_q <= vld_d;
      s1_q  <= s1_d;
      s2_q  <= s2_d;
    end
  end

  assign out_valid = vld_q[2];
  assign result    = s2_q.result;
  assign carry     = s2_q.carry;
  assign overflow  = s2_q.overflow;
  assign zero      = s2_q.zero;

endmodule

// File: tb/tb_pipelined_alu.sv
// Directed bench for pipelined_alu (WIDTH=64). Outputs are sampled on the
// falling edge; inputs change 1 time unit after the rising edge.
module tb_pipelined_alu;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0, b = '0;
  logic [3:0]   opcode = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         carry, overflow, zero;

  pipelined_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry(carry), .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // popped beats, recorded on the falling edge before the popping rising edge
  logic [W-1:0] q_res[$];
  logic         q_c[$], q_o[$], q_z[$];
  int           q_cyc[$];

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      q_res.push_back(result);
      q_c.push_back(carry);
      q_o.push_back(overflow);
      q_z.push_back(zero);
      q_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_q();
    q_res.delete(); q_c.delete(); q_o.delete(); q_z.delete(); q_cyc.delete();
  endtask

  // present one beat and hold it until accepted; returns cyc after accepting edge
  task automatic send(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                      output int acc_cyc);
    bit done = 0;
    in_valid = 1'b1; opcode = op; a = av; b = bv;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk); #1;
    end
    acc_cyc = cyc;
    if (!done) chk("send_timeout", 0, 1);
    in_valid = 1'b0; a = '0; b = '0; opcode = '0;
  endtask

  task automatic drain(input string tag, input int n);
    for (int i = 0; i < 40 && q_res.size() < n; i++) begin
      @(negedge clk); #1;
    end
    if (q_res.size() < n) chk({tag, "_timeout"}, q_res.size(), n);
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic [W-1:0] er,
                        input logic ec, input logic eo, input logic ez);
    int acc;
    clear_q();
    @(posedge clk); #1;
    send(op, av, bv, acc);
    drain(tag, 1);
    if (q_res.size() >= 1) begin
      chk({tag, "_res"}, q_res[0], er);
      chk({tag, "_carry"}, q_c[0], ec);
      chk({tag, "_ovf"}, q_o[0], eo);
      chk({tag, "_zero"}, q_z[0], ez);
      chk({tag, "_latency"}, q_cyc[0] - acc, 1);
    end
  endtask

  initial begin
    int acc, lows;
    logic [W-1:0] r1;

    // reset state
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", {carry, overflow, zero}, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clk); rst_n = 1'b1;

    run_op("add_ovf", 4'b0000, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 0, 1, 0);
    run_op("add_wrap", 4'b0000, '1, 64'd1, 64'd0, 1, 0, 1);
    run_op("sub_eq", 4'b1000, 64'd5, 64'd5, 64'd0, 1, 0, 1);
    run_op("sub_borrow", 4'b1000, 64'd0, 64'd1, '1, 0, 0, 0);
    run_op("sub_ovf", 4'b1000, 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 1, 1, 0);
`ifdef ALU_SHIFT_BY_B_EN
    run_op("shl", 4'b0001, 64'd1, 64'd4, 64'h10, 0, 0, 0);
    run_op("shr", 4'b0101, 64'h80, 64'd3, 64'h10, 0, 0, 0);
    run_op("shl_by0", 4'b0001, 64'h1234, 64'h40, 64'h1234, 0, 0, 0);
`else
    run_op("shl", 4'b0001, 64'd1, 64'd4, 64'h2, 0, 0, 0);
    run_op("shr", 4'b0101, 64'h80, 64'd3, 64'h40, 0, 0, 0);
    run_op("shl_msb", 4'b0001, 64'h8000_0000_0000_0000, 64'd0, 64'd0, 0, 0, 1);
`endif
    run_op("slt_neg", 4'b0010, '1, 64'd0, 64'd1, 0, 0, 0);
    run_op("slt_pos", 4'b0010, 64'd0, '1, 64'd0, 0, 0, 1);
    run_op("xor", 4'b0100, 64'hF0F0, 64'hFF00, 64'h0FF0, 0, 0, 0);
    run_op("or", 4'b0110, 64'hF0F0, 64'h0F00, 64'hFFF0, 0, 0, 0);
    run_op("and", 4'b0111, 64'hF0F0, 64'hFF00, 64'hF000, 0, 0, 0);
    run_op("illegal", 4'b1111, 64'd3, 64'd3, 64'd0, 0, 0, 0);

    // back-to-back stream of 8 ADDs
    clear_q(); lows = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; opcode = 4'b0000; a = 64'(i * 3); b = 64'd100;
      @(negedge clk); if (!in_ready) lows++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain("stream", 8);
    chk("stream_in_ready_lows", lows, 0);
    for (int i = 0; i < 8 && i < q_res.size(); i++) begin
      chk($sformatf("stream_res%0d", i), q_res[i], 64'(i * 3 + 100));
      chk($sformatf("stream_cyc%0d", i), q_cyc[i] - q_cyc[0], i);
    end

    // backpressure: 3 beats with the sink stalled
    clear_q();
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b1; opcode = 4'b0000; a = 64'd10; b = 64'd1;
    @(posedge clk); #1;
    a = 64'd20;
    @(posedge clk); #1;
    a = 64'd30;
    chk("bp_in_ready_low", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    r1 = result;
    chk("bp_first", r1, 64'd11);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_hold_res", result, 64'd11);
    chk("bp_hold_in_ready", in_ready, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; a = '0;
    drain("bp", 3);
    repeat (4) @(posedge clk);
    #1;
    chk("bp_count", q_res.size(), 3);
    for (int i = 0; i < 3 && i < q_res.size(); i++)
      chk($sformatf("bp_res%0d", i), q_res[i], 64'(10 * (i + 1) + 1));

    // reset with two beats in flight
    clear_q();
    out_ready = 1'b0;
    send(4'b0000, 64'd7, 64'd7, acc);
    send(4'b0110, 64'd8, 64'd1, acc);
    chk("rf_loaded", out_valid, 1);
    rst_n = 1'b0; #1;
    chk("rf_out_valid", out_valid, 0);
    chk("rf_result", result, 0);
    chk("rf_flags", {carry, overflow, zero}, 0);
    chk("rf_in_ready", in_ready, 1);
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("rf_no_stale", q_res.size(), 0);
    chk("rf_out_valid_after", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
